// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core: opcodes, ALU codes, FSM states, field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

   // Instruction field bit positions
   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_LO  = 21;
   localparam int RT_LO  = 16;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Opcodes outside the R/I-type ALU classes
   localparam logic [5:0] OP_LW   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100001;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_BNE  = 6'b110001;
   localparam logic [5:0] OP_J    = 6'b110010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   // ALU function codes (op[3:0]); 8..15 produce zero
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_HALT, C_ILLEGAL
   } iclass_e;

   // Map an opcode onto its execution class
   function automatic iclass_e op_class(input logic [5:0] op);
      iclass_e c;
      if (op[5:4] == 2'b00) begin
         c = C_RTYPE;
      end else if (op[5:4] == 2'b01) begin
         c = C_ITYPE;
      end else begin
         case (op)
            OP_LW:          c = C_LOAD;
            OP_SW:          c = C_STORE;
            OP_BEQ, OP_BNE: c = C_BRANCH;
            OP_J:           c = C_JUMP;
            OP_HALT:        c = C_HALT;
            default:        c = C_ILLEGAL;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, write visible the cycle after we_i.
// Backpressure: none; register 0 reads zero and ignores writes.
module mc_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int RIDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RIDX_W-1:0] raddr_a_i,
   input  logic [RIDX_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o,
   input  logic              we_i,
   input  logic [RIDX_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [DATA_W-1:0] regs_q [NREGS];

   // Clear on reset; writes to register 0 are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mc_core_param.sv
// Parametrised multicycle core: IR, register file, inline ALU, PC logic and sequencing FSM.
// Latency: ALU 4, LW 5, SW 4, branch/J 3 cycles, plus one per memory wait cycle.
// Backpressure: FETCH and MEM hold their requests and addresses stable until the matching ack.
module mc_core_param
   import mc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              retire,
   output logic              illegal_op,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg
);

   localparam int RIDX_W = $clog2(NREGS);

   state_e            state_q, state_d;
   logic              run_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] aluout_q, aluout_d, mdr_q, mdr_d;

   logic [5:0]        op;
   iclass_e           cls;
   logic [15:0]       imm;
   logic [DATA_W-1:0] sext;
   logic [DATA_W-1:0] alu_b, alu_res;
   logic [3:0]        alu_fn;
   logic              br_taken;
   logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
   logic [RIDX_W-1:0] rf_waddr;
   logic              rf_we;

   assign op   = ir_q[OP_HI:OP_LO];
   assign cls  = op_class(op);
   assign imm  = ir_q[IMM_HI:IMM_LO];
   assign sext = DATA_W'($signed(imm));

   mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RIDX_W(RIDX_W)) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr_a_i (ir_q[RS_LO +: RIDX_W]),
      .raddr_b_i (ir_q[RT_LO +: RIDX_W]),
      .rdata_a_o (rf_rdata_a),
      .rdata_b_o (rf_rdata_b),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (rf_wdata)
   );

   // ALU: R-type uses B, everything else uses the sign-extended immediate; loads/stores add
   always_comb begin
      alu_b    = (cls == C_RTYPE) ? b_q : sext;
      alu_fn   = ((cls == C_RTYPE) || (cls == C_ITYPE)) ? op[3:0] : ALU_ADD;
      br_taken = (a_q == b_q) ^ op[0];
      case (alu_fn)
         ALU_ADD: alu_res = a_q + alu_b;
         ALU_SUB: alu_res = a_q - alu_b;
         ALU_AND: alu_res = a_q & alu_b;
         ALU_OR:  alu_res = a_q | alu_b;
         ALU_XOR: alu_res = a_q ^ alu_b;
         ALU_SLT: alu_res = DATA_W'($signed(a_q) < $signed(alu_b));
         ALU_SLL: alu_res = a_q << alu_b[4:0];
         ALU_SRL: alu_res = a_q >> alu_b[4:0];
         default: alu_res = '0;
      endcase
   end

   // State register; run_q keeps imem_req low until the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         mdr_q    <= mdr_d;
      end
   end

   // Next state and datapath updates; PC changes exactly once per instruction
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      mdr_d    = mdr_q;
      case (state_q)
         S_FETCH: begin
            if (run_q && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cls == C_HALT) begin
               state_d = S_HALT;
            end else if (cls == C_ILLEGAL) begin
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_FETCH;
            end else begin
               a_d     = rf_rdata_a;
               b_d     = rf_rdata_b;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            aluout_d = alu_res;
            case (cls)
               C_LOAD, C_STORE: state_d = S_MEM;
               C_BRANCH: begin
                  pc_d    = br_taken ? (pc_q + ADDR_W'(1) + sext[ADDR_W-1:0])
                                     : (pc_q + ADDR_W'(1));
                  state_d = S_FETCH;
               end
               C_JUMP: begin
                  pc_d    = ADDR_W'(imm);
                  state_d = S_FETCH;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (cls == C_LOAD) begin
                  mdr_d   = dmem_rdata;
                  state_d = S_WB;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   // Outputs, handshake requests and register write port
   always_comb begin
      imem_req   = (state_q == S_FETCH) && run_q;
      dmem_req   = (state_q == S_MEM);
      dmem_we    = (state_q == S_MEM) && (cls == C_STORE);
      illegal_op = (state_q == S_DECODE) && (cls == C_ILLEGAL);
      halted     = (state_q == S_HALT);
      retire     = illegal_op
                || ((state_q == S_EXEC) && ((cls == C_BRANCH) || (cls == C_JUMP)))
                || ((state_q == S_MEM) && (cls == C_STORE) && dmem_ack)
                || (state_q == S_WB);
      rf_we      = (state_q == S_WB);
      rf_waddr   = (cls == C_RTYPE) ? ir_q[RD_LO +: RIDX_W] : ir_q[RT_LO +: RIDX_W];
      rf_wdata   = (cls == C_LOAD) ? mdr_q : aluout_q;
   end

   assign imem_addr  = pc_q;
   assign dmem_addr  = aluout_q[ADDR_W-1:0];
   assign dmem_wdata = b_q;
   assign pc_dbg     = pc_q;

endmodule

// File: tb/tb_mc_core_param.sv
// Bench for mc_core_param: instruction table stepped one retire at a time, plus reset/halt sequences.
// Latency: memories respond after a configurable number of wait cycles.
// Backpressure: ack asserted once req has been held for the configured delay.
module tb_mc_core_param;
   import mc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
   logic [15:0] imem_addr, dmem_addr, pc_dbg;
   logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
   logic        retire, illegal_op, halted;

   logic [31:0] imem [65536];
   logic [31:0] dmem_m [256];
   int          idly = 0, ddly = 0, icnt = 0, dcnt = 0;
   int          n_chk = 0, n_fail = 0;
   logic [15:0] exp_pc;

   mc_core_param #(.DATA_W(32), .ADDR_W(16), .NREGS(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .retire(retire), .illegal_op(illegal_op), .halted(halted), .pc_dbg(pc_dbg)
   );

   always #5 clk = ~clk;

   // Memory models with programmable wait states
   assign imem_ack   = imem_req && (icnt >= idly);
   assign dmem_ack   = dmem_req && (dcnt >= ddly);
   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem_m[dmem_addr[7:0]];

   always @(posedge clk) begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      if (dmem_req && dmem_ack && dmem_we) dmem_m[dmem_addr[7:0]] <= dmem_wdata;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] ins;
      int          idl, ddl, cyc;
      logic [15:0] pca;
      int          ri;
      logic [31:0] rv;
      int          il, mr;
      logic [15:0] ma;
      logic        mw;
      logic [31:0] md;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] rtype(input int f, rs, rt, rd);
      return {2'b00, 4'(f), 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, rt, input logic [15:0] im);
      return {op, 5'(rs), 5'(rt), im};
   endfunction

   function automatic vec_t mk(input logic [31:0] ins, input int idl, ddl, cyc,
                               input logic [15:0] pca, input int ri, input logic [31:0] rv,
                               input int il, mr, input logic [15:0] ma, input logic mw,
                               input logic [31:0] md);
      vec_t v;
      v.ins = ins; v.idl = idl; v.ddl = ddl; v.cyc = cyc; v.pca = pca; v.ri = ri; v.rv = rv;
      v.il = il; v.mr = mr; v.ma = ma; v.mw = mw; v.md = md;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Place one instruction at the expected PC, run it to its retire pulse and check the effects
   task automatic run_vec(input vec_t v, input int k);
      int cyc = 0, nreq = 0, nill = 0;
      logic got = 1'b0;
      logic [15:0] a = '0;
      logic [31:0] wd = '0;
      logic we = 1'b0;
      idly = v.idl;
      ddly = v.ddl;
      imem[exp_pc] = v.ins;
      while (!got && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (dmem_req) begin
            nreq++; a = dmem_addr; wd = dmem_wdata; we = dmem_we;
         end
         if (illegal_op) nill++;
         if (retire) got = 1'b1;
      end
      chk($sformatf("v%0d retire_seen", k), 32'(got), 32'd1);
      chk($sformatf("v%0d cycles", k), 32'(cyc), 32'(v.cyc));
      chk($sformatf("v%0d illegal_pulses", k), 32'(nill), 32'(v.il));
      chk($sformatf("v%0d dmem_req_cycles", k), 32'(nreq), 32'(v.mr));
      if (v.mr > 0) begin
         chk($sformatf("v%0d dmem_addr", k), 32'(a), 32'(v.ma));
         chk($sformatf("v%0d dmem_we", k), 32'(we), 32'(v.mw));
         if (v.mw) chk($sformatf("v%0d dmem_wdata", k), wd, v.md);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", k), 32'(pc_dbg), 32'(v.pca));
      chk($sformatf("v%0d reg%0d", k, v.ri), dut.u_rf.regs_q[v.ri], v.rv);
      exp_pc = v.pca;
   endtask

   // Release reset at a falling edge; imem_req must only rise after the next rising edge
   task automatic release_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({tag, " imem_req_before_clk"}, 32'(imem_req), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " imem_req_first_clk"}, 32'(imem_req), 32'd1);
      chk({tag, " imem_addr_first"}, 32'(imem_addr), 32'd0);
      exp_pc = '0;
   endtask

   initial begin
      int nreq, nret, seen;
      for (int i = 0; i < 65536; i++) imem[i] = '0;
      for (int i = 0; i < 256; i++) dmem_m[i] = '0;

      //         instr                                  idl ddl cyc  pc_after   reg  value          il mr addr  we  wdata
      tbl.push_back(mk(itype(6'b010000, 0, 1, 16'd5),       0, 0, 4, 16'd1,      1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b010000, 0, 2, 16'd7),       0, 0, 4, 16'd2,      2, 32'd7,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(rtype(1, 1, 2, 3),                   0, 0, 4, 16'd3,      3, 32'hFFFFFFFE,  0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(rtype(5, 3, 1, 4),                   0, 0, 4, 16'd4,      4, 32'd1,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(rtype(2, 2, 1, 6),                   0, 0, 4, 16'd5,      6, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(rtype(3, 1, 2, 7),                   0, 0, 4, 16'd6,      7, 32'd7,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b010100, 2, 8, 16'd3),       0, 0, 4, 16'd7,      8, 32'd4,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b010110, 1, 9, 16'd4),       0, 0, 4, 16'd8,      9, 32'h50,        0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(rtype(7, 3, 1, 10),                  0, 0, 4, 16'd9,     10, 32'h07FFFFFF,  0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b010000, 0, 11, 16'hFFFF),   0, 0, 4, 16'd10,    11, 32'hFFFFFFFF,  0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b010000, 1, 0, 16'd9),       0, 0, 4, 16'd11,     0, 32'd0,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(rtype(8, 1, 2, 12),                  0, 0, 4, 16'd12,    12, 32'd0,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b010000, 0, 13, 16'h7FFF),   2, 0, 6, 16'd13,    13, 32'h00007FFF,  0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(6'b101010, 1, 1, 16'd0),       0, 0, 2, 16'd14,     1, 32'd5,         1, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_J, 0, 0, 16'd10),           0, 0, 3, 16'd10,     1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_BEQ, 1, 1, 16'hFFFD),       0, 0, 3, 16'd8,      1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_BNE, 1, 1, 16'd5),          0, 0, 3, 16'd9,      1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_BNE, 1, 2, 16'h20),         0, 0, 3, 16'd42,     2, 32'd7,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_J, 0, 0, 16'hFFFF),         0, 0, 3, 16'hFFFF,   1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_BEQ, 0, 0, 16'd1),          0, 0, 3, 16'd1,      1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_J, 0, 0, 16'h0040),         0, 0, 3, 16'h40,     1, 32'd5,         0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(itype(OP_SW, 0, 1, 16'd8),           0, 3, 7, 16'h41,     1, 32'd5,         0, 4, 16'd8, 1, 32'd5));
      tbl.push_back(mk(itype(OP_LW, 0, 5, 16'd8),           0, 3, 8, 16'h42,     5, 32'd5,         0, 4, 16'd8, 0, 0));
      tbl.push_back(mk(itype(OP_SW, 11, 3, 16'd9),          0, 0, 4, 16'h43,     3, 32'hFFFFFFFE,  0, 1, 16'd8, 1, 32'hFFFFFFFE));
      tbl.push_back(mk(itype(OP_LW, 0, 14, 16'd8),          0, 0, 5, 16'h44,    14, 32'hFFFFFFFE,  0, 1, 16'd8, 0, 0));

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst imem_req", 32'(imem_req), 32'd0);
      chk("rst dmem_req", 32'(dmem_req), 32'd0);
      chk("rst dmem_we", 32'(dmem_we), 32'd0);
      chk("rst retire", 32'(retire), 32'd0);
      chk("rst illegal_op", 32'(illegal_op), 32'd0);
      chk("rst halted", 32'(halted), 32'd0);
      chk("rst pc_dbg", 32'(pc_dbg), 32'd0);
      release_reset("rel0");

      for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], k);
      chk("dmem word8 after wrap store", dmem_m[8], 32'hFFFFFFFE);

      // HALT: one fetch, then halted with no further requests or retires
      imem[exp_pc] = {OP_HALT, 26'd0};
      nreq = 0; nret = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req || dmem_req) nreq++;
         if (retire) nret++;
      end
      chk("halt halted", 32'(halted), 32'd1);
      chk("halt req_cycles", 32'(nreq), 32'd1);
      chk("halt retires", 32'(nret), 32'd0);
      chk("halt pc", 32'(pc_dbg), 32'h44);

      // Reset out of HALT clears state asynchronously
      #2 rst_n = 1'b0;
      #1;
      chk("rst2 halted", 32'(halted), 32'd0);
      chk("rst2 pc", 32'(pc_dbg), 32'd0);
      chk("rst2 reg1", dut.u_rf.regs_q[1], 32'd0);
      chk("rst2 reg5", dut.u_rf.regs_q[5], 32'd0);
      repeat (2) @(posedge clk);
      release_reset("rel2");
      imem[1] = '0;
      run_vec(tbl[0], 100);

      // Reset in the middle of a stalled store abandons it without a clock edge
      imem[1] = itype(OP_SW, 0, 1, 16'd3);
      ddly = 50;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (dmem_req) seen = 1;
      end
      chk("mid seen dmem_req", 32'(seen), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid dmem_req dropped", 32'(dmem_req), 32'd0);
      chk("mid dmem_we dropped", 32'(dmem_we), 32'd0);
      chk("mid pc", 32'(pc_dbg), 32'd0);
      chk("mid reg1", dut.u_rf.regs_q[1], 32'd0);
      chk("mid no store", dmem_m[3], 32'd0);
      repeat (2) @(posedge clk);
      release_reset("rel3");
      run_vec(tbl[0], 101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
